fcore_bitmanip_arbiter: RTL and testbench

Round-robin arbiter that shares one fCore bitmanip execution unit between N_REQUESTERS fCore pipelines. It grants at most one request per cycle and drives the unit's operand, operation and user channels. The requester index is carried through the unit's user field, so each fixed-latency result is routed back to the requester that issued it. It sits between the fCore issue stages and a single shared bitmanip unit.

---
 rtl/fcore_bitmanip_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fcore_bitmanip_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcore_bitmanip_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fCore bitmanip unit between N_REQUESTERS pipelines.
// Optional per-requester grant and conflict statistics are enabled by defining FCORE_BITMANIP_ARB_STATS_EN.
module fcore_bitmanip_arbiter #(
  parameter int N_REQUESTERS   = 4,
  parameter int PIPELINE_DEPTH = 5,
  parameter int DEST_WIDTH     = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [N_REQUESTERS-1:0]          req_valid,
  output logic [N_REQUESTERS-1:0]          req_ready,
  input  logic [8*N_REQUESTERS-1:0]        req_opcode,
  input  logic [32*N_REQUESTERS-1:0]       req_a,
  input  logic [32*N_REQUESTERS-1:0]       req_b,
  input  logic [32*N_REQUESTERS-1:0]       req_c,
  input  logic [DEST_WIDTH*N_REQUESTERS-1:0] req_dest,
  output logic                             unit_valid,
  output logic [31:0]                      unit_a,
  output logic [31:0]                      unit_b,
  output logic [31:0]                      unit_c,
  output logic [31:0]                      unit_op,
  output logic [31:0]                      unit_user,
  input  logic                             unit_res_valid,
  input  logic [31:0]                      unit_res_data,
  input  logic [31:0]                      unit_res_user,
  output logic [N_REQUESTERS-1:0]          res_valid,
  output logic [31:0]                      res_data,
  output logic [DEST_WIDTH-1:0]            res_dest,
  output logic                             idle,
  output logic                             illegal_op,
  output logic                             orphan_result
`ifdef FCORE_BITMANIP_ARB_STATS_EN
  ,
  output logic [32*N_REQUESTERS-1:0]       grant_count,
  output logic [31:0]                      conflict_count
`endif
);

  localparam int PTR_W = (N_REQUESTERS > 1) ? $clog2(N_REQUESTERS) : 1;
  localparam int CNT_W = $clog2(PIPELINE_DEPTH + 2);

  logic [7:0]            opcode_arr [N_REQUESTERS];
  logic [31:0]           a_arr      [N_REQUESTERS];
  logic [31:0]           b_arr      [N_REQUESTERS];
  logic [31:0]           c_arr      [N_REQUESTERS];
  logic [DEST_WIDTH-1:0] dest_arr   [N_REQUESTERS];

  logic [PTR_W-1:0]        ptr_reg;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        cand;
  logic                    grant_found;
  logic                    sel_legal;
  logic                    issue;
  logic                    issue_valid_reg;
  logic [31:0]             unit_a_reg, unit_b_reg, unit_c_reg, unit_user_reg;
  logic [7:0]              unit_op_reg;
  logic [CNT_W-1:0]        inflight_reg;
  logic                    res_orphan;
  logic                    res_route;
  logic [N_REQUESTERS-1:0] res_hit;
  logic [N_REQUESTERS-1:0] res_valid_reg;
  logic [31:0]             res_data_reg;
  logic [DEST_WIDTH-1:0]   res_dest_reg;
  logic                    illegal_reg;
  logic                    orphan_reg;
  logic                    unused_user_bits;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQUESTERS; gi++) begin : g_unpack
      assign opcode_arr[gi] = req_opcode[8*gi +: 8];
      assign a_arr[gi]      = req_a[32*gi +: 32];
      assign b_arr[gi]      = req_b[32*gi +: 32];
      assign c_arr[gi]      = req_c[32*gi +: 32];
      assign dest_arr[gi]   = req_dest[DEST_WIDTH*gi +: DEST_WIDTH];
      assign req_ready[gi]  = grant_found && (grant_idx == PTR_W'(gi));
      assign res_hit[gi]    = res_route && (unit_res_user[31:24] == 8'(gi));
    end
  endgenerate

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < N_REQUESTERS; off++) begin
      cand = PTR_W'((int'(ptr_reg) + off) % N_REQUESTERS);
      if (enable && !grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign sel_legal = (opcode_arr[grant_idx] == 8'd3) || (opcode_arr[grant_idx] == 8'd5) ||
                     (opcode_arr[grant_idx] == 8'd7);
  assign issue     = grant_found && sel_legal;

  // A result is only trusted when something is in flight and its index names a real requester.
  assign res_orphan = unit_res_valid && ((inflight_reg == '0) ||
                                         (unit_res_user[31:24] >= 8'(N_REQUESTERS)));
  assign res_route  = unit_res_valid && !res_orphan;
  assign unused_user_bits = ^unit_res_user[23:DEST_WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg         <= '0;
      issue_valid_reg <= 1'b0;
      unit_a_reg      <= '0;
      unit_b_reg      <= '0;
      unit_c_reg      <= '0;
      unit_op_reg     <= '0;
      unit_user_reg   <= '0;
      inflight_reg    <= '0;
      res_valid_reg   <= '0;
      res_data_reg    <= '0;
      res_dest_reg    <= '0;
      illegal_reg     <= 1'b0;
      orphan_reg      <= 1'b0;
    end else begin
      if (grant_found) begin
        ptr_reg <= (grant_idx == PTR_W'(N_REQUESTERS - 1)) ? '0 : grant_idx + PTR_W'(1);
      end

      issue_valid_reg <= issue;
      unit_a_reg      <= issue ? a_arr[grant_idx] : '0;
      unit_b_reg      <= issue ? b_arr[grant_idx] : '0;
      unit_c_reg      <= issue ? c_arr[grant_idx] : '0;
      unit_op_reg     <= issue ? opcode_arr[grant_idx] : '0;
      unit_user_reg   <= issue ? {8'(grant_idx), 8'h00, 16'(dest_arr[grant_idx])} : '0;

      if (grant_found && !sel_legal) illegal_reg <= 1'b1;
      if (res_orphan)                orphan_reg  <= 1'b1;

      res_valid_reg <= res_hit;
      if (res_route) begin
        res_data_reg <= unit_res_data;
        res_dest_reg <= unit_res_user[DEST_WIDTH-1:0];
      end

      case ({issue, res_route})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  assign unit_valid    = issue_valid_reg;
  assign unit_a        = unit_a_reg;
  assign unit_b        = unit_b_reg;
  assign unit_c        = unit_c_reg;
  assign unit_op       = {24'h0, unit_op_reg};
  assign unit_user     = unit_user_reg;
  assign res_valid     = res_valid_reg;
  assign res_data      = res_data_reg;
  assign res_dest      = res_dest_reg;
  assign idle          = (inflight_reg == '0) && !issue_valid_reg;
  assign illegal_op    = illegal_reg;
  assign orphan_result = orphan_reg;

`ifdef FCORE_BITMANIP_ARB_STATS_EN
  logic [31:0] conflict_count_reg;

  generate
    for (gi = 0; gi < N_REQUESTERS; gi++) begin : g_grant_stats
      logic [31:0] cnt_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (issue && (grant_idx == PTR_W'(gi)) && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
      assign grant_count[32*gi +: 32] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_count_reg <= '0;
    end else if (enable && ($countones(req_valid) >= 2) && (conflict_count_reg != '1)) begin
      conflict_count_reg <= conflict_count_reg + 32'd1;
    end
  end

  assign conflict_count = conflict_count_reg;
`endif

endmodule

// File: tb/tb_fcore_bitmanip_arbiter.sv
// Directed self-checking bench for fcore_bitmanip_arbiter with a fixed-latency unit model.
module tb_fcore_bitmanip_arbiter;

  localparam int N  = 4;
  localparam int PD = 5;
  localparam int DW = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [8*N-1:0]    req_opcode;
  logic [32*N-1:0]   req_a, req_b, req_c;
  logic [DW*N-1:0]   req_dest;
  logic              unit_valid;
  logic [31:0]       unit_a, unit_b, unit_c, unit_op, unit_user;
  logic              unit_res_valid;
  logic [31:0]       unit_res_data, unit_res_user;
  logic [N-1:0]      res_valid;
  logic [31:0]       res_data;
  logic [DW-1:0]     res_dest;
  logic              idle, illegal_op, orphan_result;

  int checks = 0;
  int errors = 0;

  // Fixed-latency unit model: result appears PD cycles after unit_valid.
  logic        pipe_v [PD];
  logic [31:0] pipe_d [PD];
  logic [31:0] pipe_u [PD];
  logic        force_v;
  logic [31:0] force_u;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PD; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
        pipe_u[i] <= '0;
      end
    end else begin
      pipe_v[0] <= unit_valid;
      pipe_d[0] <= unit_a ^ 32'hA5A5_0000;
      pipe_u[0] <= unit_user;
      for (int i = 1; i < PD; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
        pipe_u[i] <= pipe_u[i-1];
      end
    end
  end

  assign unit_res_valid = force_v | pipe_v[PD-1];
  assign unit_res_data  = force_v ? 32'hDEAD_BEEF : pipe_d[PD-1];
  assign unit_res_user  = force_v ? force_u : pipe_u[PD-1];

  fcore_bitmanip_arbiter #(
    .N_REQUESTERS(N),
    .PIPELINE_DEPTH(PD),
    .DEST_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_opcode(req_opcode),
    .req_a(req_a),
    .req_b(req_b),
    .req_c(req_c),
    .req_dest(req_dest),
    .unit_valid(unit_valid),
    .unit_a(unit_a),
    .unit_b(unit_b),
    .unit_c(unit_c),
    .unit_op(unit_op),
    .unit_user(unit_user),
    .unit_res_valid(unit_res_valid),
    .unit_res_data(unit_res_data),
    .unit_res_user(unit_res_user),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_dest(res_dest),
    .idle(idle),
    .illegal_op(illegal_op),
    .orphan_result(orphan_result)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] op, input logic [31:0] a,
                         input logic [15:0] dest);
    req_opcode[8*r +: 8]  = op;
    req_a[32*r +: 32]     = a;
    req_b[32*r +: 32]     = 32'(r);
    req_c[32*r +: 32]     = 32'(r & 1);
    req_dest[DW*r +: DW]  = dest;
  endtask

  function automatic logic [31:0] def_a(input int r);
    return 32'h1000_0000 + 32'(r);
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    enable    = 1'b1;
    force_v   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++;
    if (unit_valid !== 1'b0 || unit_user !== 32'h0 || unit_a !== 32'h0) begin
      errors++; $display("FAIL reset_unit got v=%b user=%h a=%h want 0", unit_valid, unit_user, unit_a);
    end
    checks++;
    if (res_valid !== '0 || res_data !== 32'h0 || res_dest !== '0) begin
      errors++; $display("FAIL reset_res got v=%b d=%h t=%h want 0", res_valid, res_data, res_dest);
    end
    checks++;
    if (illegal_op !== 1'b0 || orphan_result !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_flags got ill=%b orph=%b rdy=%b want 0", illegal_op, orphan_result, req_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    set_req(2, 8'd3, 32'h0000_00FF, 16'h0012);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (unit_valid !== 1'b1 || unit_user !== 32'h0200_0012 || unit_a !== 32'h0000_00FF ||
        unit_op !== 32'd3 || unit_b !== 32'd2) begin
      errors++; $display("FAIL single_issue got v=%b user=%h a=%h op=%h b=%h want 1 02000012 000000ff 3 2",
                         unit_valid, unit_user, unit_a, unit_op, unit_b);
    end
    checks++;
    if (idle !== 1'b0) begin errors++; $display("FAIL single_busy got idle=%b want 0", idle); end
    repeat (5) tick();
    checks++;
    if (res_valid !== 4'b0000) begin errors++; $display("FAIL single_early got %b want 0000", res_valid); end
    tick();
    checks++;
    if (res_valid !== 4'b0100 || res_dest !== 16'h0012 || res_data !== 32'hA5A5_00FF) begin
      errors++; $display("FAIL single_result got v=%b t=%h d=%h want 0100 0012 a5a500ff", res_valid, res_dest, res_data);
    end
    tick();
    checks++;
    if (idle !== 1'b1 || res_valid !== 4'b0000) begin
      errors++; $display("FAIL single_idle got idle=%b v=%b want 1 0000", idle, res_valid);
    end
    set_req(2, 8'd5, def_a(2), 16'h0102);
    $display("test_single done: req 2 dest 0012");
  endtask

  task automatic test_sparse_rr();
    logic [N-1:0] exp_rdy [3];
    exp_rdy[0] = 4'b1000;
    exp_rdy[1] = 4'b0001;
    exp_rdy[2] = 4'b1000;
    req_valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_rdy[c]) begin
        errors++; $display("FAIL sparse_grant%0d got %b want %b", c, req_ready, exp_rdy[c]);
      end
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL sparse_drain got idle=%b want 1", idle); end
    $display("test_sparse_rr done");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_hot;
    req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) begin
        exp_hot = 4'b0001 << (c % 4);
        checks++;
        if (req_ready !== exp_hot) begin
          errors++; $display("FAIL b2b_grant c=%0d got %b want %b", c, req_ready, exp_hot);
        end
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (unit_valid !== 1'b1 || unit_user[31:24] !== 8'((c - 1) % 4)) begin
          errors++; $display("FAIL b2b_issue c=%0d got v=%b idx=%0d want 1 %0d", c, unit_valid, unit_user[31:24], (c - 1) % 4);
        end
      end
      if (c == 9) begin
        checks++;
        if (unit_valid !== 1'b0) begin errors++; $display("FAIL b2b_issue_end got %b want 0", unit_valid); end
      end
      if (c >= 7 && c < 15) begin
        exp_hot = 4'b0001 << ((c - 7) % 4);
        checks++;
        if (res_valid !== exp_hot || res_data !== (def_a((c - 7) % 4) ^ 32'hA5A5_0000) ||
            res_dest !== 16'h0100 + 16'((c - 7) % 4)) begin
          errors++; $display("FAIL b2b_result c=%0d got v=%b d=%h t=%h want %b", c, res_valid, res_data, res_dest, exp_hot);
        end
      end
      if (c == 15) begin
        checks++;
        if (res_valid !== '0 || idle !== 1'b1) begin
          errors++; $display("FAIL b2b_drain got v=%b idle=%b want 0000 1", res_valid, idle);
        end
      end
      tick();
    end
    $display("test_back_to_back done: 8 grants");
  endtask

  task automatic test_illegal();
    set_req(1, 8'd4, def_a(1), 16'h0101);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL illegal_ready got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (unit_valid !== 1'b0 || illegal_op !== 1'b1 || idle !== 1'b1) begin
      errors++; $display("FAIL illegal_drop got v=%b ill=%b idle=%b want 0 1 1", unit_valid, illegal_op, idle);
    end
    repeat (8) tick();
    checks++;
    if (illegal_op !== 1'b1 || res_valid !== '0 || orphan_result !== 1'b0) begin
      errors++; $display("FAIL illegal_sticky got ill=%b v=%b orph=%b want 1 0000 0", illegal_op, res_valid, orphan_result);
    end
    set_req(1, 8'd5, def_a(1), 16'h0101);
    $display("test_illegal done: req 1 opcode 4");
  endtask

  task automatic test_enable_drop();
    logic [N-1:0] exp_hot [3];
    exp_hot[0] = 4'b0100;
    exp_hot[1] = 4'b1000;
    exp_hot[2] = 4'b0001;
    req_valid = 4'hF;
    for (int c = 0; c < 11; c++) begin
      if (c == 3) enable = 1'b0;
      #1;
      if (c < 3) begin
        checks++;
        if (req_ready !== exp_hot[c]) begin
          errors++; $display("FAIL drop_grant c=%0d got %b want %b", c, req_ready, exp_hot[c]);
        end
      end else begin
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL drop_ready c=%0d got %b want 0000", c, req_ready); end
      end
      if (c == 3) begin
        checks++;
        if (unit_valid !== 1'b1) begin errors++; $display("FAIL drop_last_issue got %b want 1", unit_valid); end
      end
      if (c >= 7 && c <= 9) begin
        checks++;
        if (res_valid !== exp_hot[c - 7]) begin
          errors++; $display("FAIL drop_result c=%0d got %b want %b", c, res_valid, exp_hot[c - 7]);
        end
      end
      if (c == 8) begin
        checks++;
        if (idle !== 1'b0) begin errors++; $display("FAIL drop_busy got idle=%b want 0", idle); end
      end
      if (c == 10) begin
        checks++;
        if (idle !== 1'b1 || res_valid !== '0) begin
          errors++; $display("FAIL drop_idle got idle=%b v=%b want 1 0000", idle, res_valid);
        end
      end
      tick();
    end
    req_valid = '0;
    enable    = 1'b1;
    $display("test_enable_drop done: 3 results");
  endtask

  task automatic test_orphan();
    do_reset();
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL orphan_ready got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    force_v   = 1'b1;
    force_u   = 32'h0900_0000;
    tick();
    force_v = 1'b0;
    checks++;
    if (orphan_result !== 1'b1 || res_valid !== '0) begin
      errors++; $display("FAIL orphan_index got orph=%b v=%b want 1 0000", orphan_result, res_valid);
    end
    repeat (5) tick();
    checks++;
    if (res_valid !== 4'b0001 || res_data !== (def_a(0) ^ 32'hA5A5_0000)) begin
      errors++; $display("FAIL orphan_genuine got v=%b d=%h want 0001", res_valid, res_data);
    end
    tick();
    do_reset();
    checks++;
    if (orphan_result !== 1'b0) begin errors++; $display("FAIL orphan_clear got %b want 0", orphan_result); end
    force_v = 1'b1;
    force_u = 32'h0100_0033;
    tick();
    force_v = 1'b0;
    checks++;
    if (orphan_result !== 1'b1 || res_valid !== '0 || idle !== 1'b1) begin
      errors++; $display("FAIL orphan_count0 got orph=%b v=%b idle=%b want 1 0000 1", orphan_result, res_valid, idle);
    end
    $display("test_orphan done");
  endtask

  task automatic test_reset_midstream();
    logic [N-1:0] seen;
    do_reset();
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (idle !== 1'b1 || unit_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_idle got idle=%b v=%b want 1 0", idle, unit_valid);
    end
    seen = '0;
    for (int c = 0; c < 10; c++) begin
      seen |= res_valid;
      tick();
    end
    checks++;
    if (seen !== '0 || orphan_result !== 1'b0) begin
      errors++; $display("FAIL midreset_stale got v=%b orph=%b want 0000 0", seen, orphan_result);
    end
    $display("test_reset_midstream done");
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    req_valid  = '0;
    force_v    = 1'b0;
    force_u    = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_c      = '0;
    req_dest   = '0;
    for (int r = 0; r < N; r++) set_req(r, 8'd5, def_a(r), 16'h0100 + 16'(r));
    test_reset();
    test_single();
    test_sparse_rr();
    test_back_to_back();
    test_illegal();
    test_enable_drop();
    test_orphan();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
